// File: rtl/writeback_stage.sv
// Retire stage: holds one instruction, waits for load data when needed, drives the
// register-file write port and merges the in-flight write into decode's operands.
module writeback_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wb_en,
  input  logic [REG_AW-1:0]   in_rd_addr,
  input  logic [2:0]          in_ppp,
  input  logic                in_is_load,
  input  logic [0:DATA_W-1]   in_result,
  input  logic                dmem_valid,
  input  logic [0:DATA_W-1]   dmem_data,
  input  logic                flush,
  output logic                writeEnable,
  output logic [REG_AW-1:0]   rD_address,
  output logic [0:DATA_W-1]   rD_data,
  output logic [2:0]          ppp,
  input  logic [REG_AW-1:0]   rA_address,
  input  logic [REG_AW-1:0]   rB_address,
  input  logic [0:DATA_W-1]   rA_data,
  input  logic [0:DATA_W-1]   rB_data,
  output logic [0:DATA_W-1]   fwdA_data,
  output logic [0:DATA_W-1]   fwdB_data,
  output logic [CNT_W-1:0]    wb_count
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    HOLD      = 2'd1,
    WAIT_LOAD = 2'd2
  } stateType;

  stateType            stateReg, stateNext;
  logic                wbEnReg;
  logic [REG_AW-1:0]   rdAddrReg;
  logic [2:0]          pppReg;
  logic [0:DATA_W-1]   resultReg;
  logic [CNT_W-1:0]    countReg;
  logic                accept;
  logic                presenting;
  logic [0:NB-1]       byteMask;
  logic                hitA, hitB;

  always_comb begin
    in_ready   = 1'b1;
    presenting = 1'b0;
    stateNext  = EMPTY;
    case (stateReg)
      HOLD:      presenting = 1'b1;
      WAIT_LOAD: begin
        presenting = dmem_valid;
        in_ready   = dmem_valid;
      end
      default:   presenting = 1'b0;
    endcase
    accept = in_valid && in_ready && !flush;
    // A load that has not returned keeps the stage occupied; flush abandons it.
    if (flush)
      stateNext = EMPTY;
    else if (accept)
      stateNext = in_is_load ? WAIT_LOAD : HOLD;
    else if (stateReg == WAIT_LOAD && !dmem_valid)
      stateNext = WAIT_LOAD;
    else
      stateNext = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= EMPTY;
      wbEnReg   <= 1'b0;
      rdAddrReg <= '0;
      pppReg    <= 3'd0;
      resultReg <= '0;
      countReg  <= '0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        wbEnReg   <= in_wb_en;
        rdAddrReg <= in_rd_addr;
        pppReg    <= in_ppp;
        resultReg <= in_result;
      end
      if (writeEnable)
        countReg <= countReg + 1'b1;
    end
  end

  assign rD_address  = rdAddrReg;
  assign ppp         = pppReg;
  assign rD_data     = (stateReg == WAIT_LOAD) ? dmem_data : resultReg;
  assign writeEnable = wbEnReg && presenting && (rdAddrReg != '0)
                       && (pppReg <= 3'd4) && !flush;
  assign wb_count    = countReg;

  assign hitA = writeEnable && (rA_address == rdAddrReg);
  assign hitB = writeEnable && (rB_address == rdAddrReg);

  // Byte 0 is the most significant byte; halves and even/odd lanes follow that order.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : gByte
      localparam bit LOW_HALF = (gi < NB / 2);
      localparam bit EVEN     = ((gi % 2) == 0);
      assign byteMask[gi] = (pppReg == 3'd0)
                          | ((pppReg == 3'd1) &  LOW_HALF)
                          | ((pppReg == 3'd2) & !LOW_HALF)
                          | ((pppReg == 3'd3) &  EVEN)
                          | ((pppReg == 3'd4) & !EVEN);
      assign fwdA_data[8*gi +: 8] = (hitA && byteMask[gi]) ? rD_data[8*gi +: 8]
                                                           : rA_data[8*gi +: 8];
      assign fwdB_data[8*gi +: 8] = (hitB && byteMask[gi]) ? rD_data[8*gi +: 8]
                                                           : rB_data[8*gi +: 8];
    end
  endgenerate

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_wb_en, in_is_load;
  logic [4:0]  in_rd_addr;
  logic [2:0]  in_ppp;
  logic [0:63] in_result;
  logic        dmem_valid;
  logic [0:63] dmem_data;
  logic        flush;
  logic        writeEnable;
  logic [4:0]  rD_address;
  logic [0:63] rD_data;
  logic [2:0]  ppp;
  logic [4:0]  rA_address, rB_address;
  logic [0:63] rA_data, rB_data, fwdA_data, fwdB_data;
  logic [15:0] wb_count;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(64), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
    .in_rd_addr(in_rd_addr), .in_ppp(in_ppp), .in_is_load(in_is_load),
    .in_result(in_result), .dmem_valid(dmem_valid), .dmem_data(dmem_data),
    .flush(flush), .writeEnable(writeEnable), .rD_address(rD_address),
    .rD_data(rD_data), .ppp(ppp), .rA_address(rA_address), .rB_address(rB_address),
    .rA_data(rA_data), .rB_data(rB_data), .fwdA_data(fwdA_data),
    .fwdB_data(fwdB_data), .wb_count(wb_count)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: %h", tag, got);
    end
  endtask

  task automatic issue(input logic wbEn, input logic [4:0] addr, input logic [2:0] sel,
                       input logic isLoad, input logic [63:0] result);
    in_valid   = 1'b1;
    in_wb_en   = wbEn;
    in_rd_addr = addr;
    in_ppp     = sel;
    in_is_load = isLoad;
    in_result  = result;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dmem_valid = 1'b0; dmem_data = '0;
    rA_address = 5'd7; rB_address = 5'd8;
    rA_data = 64'h1111111111111111; rB_data = 64'h2222222222222222;
    issue(1'b1, 5'd5, 3'd0, 1'b0, 64'h0123456789ABCDEF);

    // Reset with in_valid held high
    nextCycle(); #1;
    checkVal("rst_we", writeEnable, 0);
    checkVal("rst_ready", in_ready, 1);
    checkVal("rst_count", wb_count, 0);
    checkVal("rst_rdaddr", rD_address, 0);
    checkVal("rst_rddata", rD_data, 0);
    checkVal("rst_fwdA", fwdA_data, 64'h1111111111111111);
    nextCycle(); reset = 1'b0;

    // ALU write to r5, one-cycle latency
    nextCycle(); in_valid = 1'b0; #1;
    checkVal("alu_we", writeEnable, 1);
    checkVal("alu_addr", rD_address, 5);
    checkVal("alu_data", rD_data, 64'h0123456789ABCDEF);
    nextCycle(); #1;
    checkVal("alu_count", wb_count, 1);
    checkVal("alu_idle_we", writeEnable, 0);

    // r0 and ppp 101 writes are suppressed
    issue(1'b1, 5'd0, 3'd0, 1'b0, 64'hDEAD);
    nextCycle(); in_valid = 1'b0; #1;
    checkVal("r0_we", writeEnable, 0);
    issue(1'b1, 5'd9, 3'd5, 1'b0, 64'hBEEF);
    nextCycle(); in_valid = 1'b0; #1;
    checkVal("ppp5_we", writeEnable, 0);
    nextCycle(); #1;
    checkVal("suppr_count", wb_count, 1);

    // Load to r3 with data three cycles late, ALU to r4 queued behind it
    issue(1'b1, 5'd3, 3'd0, 1'b1, 64'h0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      issue(1'b1, 5'd4, 3'd0, 1'b0, 64'h0000000000000055); #1;
      checkVal($sformatf("load_ready%0d", i), in_ready, 0);
      checkVal($sformatf("load_we%0d", i), writeEnable, 0);
    end
    nextCycle(); dmem_valid = 1'b1; dmem_data = 64'hFFFF0000FFFF0000; #1;
    checkVal("load_done_ready", in_ready, 1);
    checkVal("load_done_we", writeEnable, 1);
    checkVal("load_done_addr", rD_address, 3);
    checkVal("load_done_data", rD_data, 64'hFFFF0000FFFF0000);
    nextCycle(); dmem_valid = 1'b0; dmem_data = '0; in_valid = 1'b0; #1;
    checkVal("queued_we", writeEnable, 1);
    checkVal("queued_addr", rD_address, 4);
    checkVal("queued_data", rD_data, 64'h55);
    checkVal("queued_count", wb_count, 2);
    nextCycle(); #1;
    checkVal("load_count", wb_count, 3);

    // Forwarding, back-to-back writes to r7
    issue(1'b1, 5'd7, 3'd3, 1'b0, 64'hAAAAAAAAAAAAAAAA);
    nextCycle(); issue(1'b1, 5'd7, 3'd2, 1'b0, 64'hAAAAAAAAAAAAAAAA); #1;
    checkVal("fwdA_ppp3", fwdA_data, 64'hAA11AA11AA11AA11);
    checkVal("fwdB_miss", fwdB_data, 64'h2222222222222222);
    nextCycle(); in_valid = 1'b0; rB_address = 5'd7; #1;
    checkVal("fwdA_ppp2", fwdA_data, 64'h11111111AAAAAAAA);
    checkVal("fwdB_ppp2", fwdB_data, 64'h22222222AAAAAAAA);
    checkVal("b2b_count", wb_count, 4);
    nextCycle(); #1;
    checkVal("fwd_count", wb_count, 5);
    checkVal("fwdA_idle", fwdA_data, 64'h1111111111111111);

    // Flush during a pending load, coinciding with dmem_valid and in_valid
    issue(1'b1, 5'd2, 3'd0, 1'b1, 64'h0);
    nextCycle(); in_valid = 1'b0; #1;
    checkVal("flush_pre_ready", in_ready, 0);
    nextCycle(); flush = 1'b1; dmem_valid = 1'b1; dmem_data = 64'h1234;
    issue(1'b1, 5'd6, 3'd0, 1'b0, 64'h77); #1;
    checkVal("flush_we", writeEnable, 0);
    nextCycle(); flush = 1'b0; dmem_valid = 1'b0; in_valid = 1'b0; #1;
    checkVal("flush_post_ready", in_ready, 1);
    checkVal("flush_post_we", writeEnable, 0);
    checkVal("flush_count", wb_count, 5);

    // Asynchronous reset mid-load discards it
    issue(1'b1, 5'd2, 3'd0, 1'b1, 64'h0);
    nextCycle(); in_valid = 1'b0; #1;
    checkVal("arst_pre_ready", in_ready, 0);
    #1 reset = 1'b1; #1;
    checkVal("arst_ready", in_ready, 1);
    checkVal("arst_count", wb_count, 0);
    nextCycle(); reset = 1'b0;

    // Counter wrap: 65536 writes from zero
    issue(1'b1, 5'd1, 3'd0, 1'b0, 64'h1);
    repeat (65536) nextCycle();
    in_valid = 1'b0; #1;
    checkVal("wrap_pre_count", wb_count, 16'hFFFF);
    checkVal("wrap_pre_we", writeEnable, 1);
    nextCycle(); #1;
    checkVal("wrap_count", wb_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the CPU. It holds one retiring instruction, waits for load data when needed, and drives the register-file write port (`writeEnable`, `rD_address`, `rD_data`, `ppp`). It also supplies same-cycle forwarded operands to decode, merged per the partial-write field, so decode never sees stale register-file data for a register being written this cycle. It back-pressures the upstream stage while a load is outstanding.

## Interface
Parameters:
- `DATA_W`, 64: datapath width; bits numbered `[0:DATA_W-1]`, bit 0 is the MSB; byte k is bits `[8k:8k+7]`.
- `REG_AW`, 5: register address width.
- `CNT_W`, 16: retire-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_wb_en`  in  1  instruction writes a register.
- `in_rd_addr`  in  REG_AW  destination register.
- `in_ppp`  in  3  partial-write select.
- `in_is_load`  in  1  result comes from data memory.
- `in_result`  in  DATA_W  ALU result (ignored for loads).
- `dmem_valid`  in  1  load data valid this cycle.
- `dmem_data`  in  DATA_W  load data.
- `flush`  in  1  kill the held instruction.
- `writeEnable`  out  1  register-file write strobe.
- `rD_address`  out  REG_AW  write address.
- `rD_data`  out  DATA_W  write data.
- `ppp`  out  3  partial-write select to the register file.
- `rA_address`, `rB_address`  in  REG_AW  decode read addresses.
- `rA_data`, `rB_data`  in  DATA_W  register-file read data.
- `fwdA_data`, `fwdB_data`  out  DATA_W  forwarded operands.
- `wb_count`  out  CNT_W  count of committed writes.

## Operation
- State machine: EMPTY, HOLD (ALU result held), WAIT_LOAD (load pending).
- Accept means `in_valid && in_ready && !flush`. On accept, capture `in_wb_en`, `in_rd_addr`, `in_ppp`, and `in_result`.
  - Next state is WAIT_LOAD if `in_is_load`, otherwise HOLD.
- `in_ready` = 0 only when in WAIT_LOAD and `dmem_valid` = 0; otherwise 1.
- HOLD: the entry is presented for exactly one cycle.
  - Next state is a newly accepted entry's state, or EMPTY.
- WAIT_LOAD: the state persists until `dmem_valid`.
  - In the `dmem_valid` cycle the write is presented with `rD_data` = `dmem_data` (combinational pass-through).
  - Next state is a newly accepted entry's state, or EMPTY.
- `writeEnable` = `wb_en_q` && (state = HOLD, or WAIT_LOAD && `dmem_valid`) && `rD_address` != 0 && `ppp` ∈ {000..100} && !`flush`.
- `rD_address` and `ppp` come from the captured fields. `rD_data` is `result_q` in HOLD and `dmem_data` in WAIT_LOAD.
- Byte mask for `ppp`:
  - 000: all bytes.
  - 001: bytes 0–3 (bits 0:31).
  - 010: bytes 4–7 (bits 32:63).
  - 011: bytes 0, 2, 4, 6.
  - 100: bytes 1, 3, 5, 7.
  - 101–111: no bytes; write suppressed.
- Forwarding: `fwdA_data` = `rA_data`, with each masked byte replaced by `rD_data`, when `writeEnable` && `rA_address` == `rD_address`. Otherwise `fwdA_data` = `rA_data`. `fwdB_data` works the same way. Forwarding is purely combinational.
- `flush`:
  - Forces `writeEnable` to 0 that cycle.
  - Blocks acceptance.
  - Next state is EMPTY, including abandoning a pending load; a `dmem_valid` arriving in the flush cycle is ignored.
- `wb_count` increments by 1 on each edge where `writeEnable` = 1 and wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous) sets: state EMPTY; all captured fields 0; `writeEnable` 0; `rD_address` 0; `rD_data` 0; `ppp` 000; `in_ready` 1; `wb_count` 0; `fwdA_data`/`fwdB_data` equal to `rA_data`/`rB_data`. Reset mid-load discards the load.
- ALU instruction accepted at edge N: the write is presented in cycle N..N+1 and commits in the register file at edge N+1 (one-cycle latency).
- Load accepted at edge N, `dmem_valid` in cycle M ≥ N: the write is presented in cycle M and commits at edge M+1.
- Back-to-back ALU instructions give one write per cycle with no bubbles.
- Accept is allowed in the same cycle that a load completes.
- `flush` together with `in_valid` accepts nothing. The cycle after a flush, the stage is EMPTY with `in_ready` = 1.

## Test plan
- Reset with `in_valid` = 1 asserted → `writeEnable` 0, `in_ready` 1, `wb_count` 0. After release, ALU instruction with r5, ppp 000, result 0x0123456789ABCDEF → next cycle `writeEnable` 1, `rD_address` 5, `rD_data` 0x0123456789ABCDEF, `wb_count` 1.
- Write to r0, ppp 000 → `writeEnable` 0, `wb_count` unchanged. Write with ppp 101 → suppressed.
- Load to r3, `dmem_valid` arriving 3 cycles late with data 0xFFFF0000FFFF0000 → `in_ready` 0 for 3 cycles, then a single write of that data to r3 while a queued ALU instruction is accepted the same edge.
- Forwarding: `rA_data` 0x1111111111111111, write to r7 with ppp 011 and data 0xAAAAAAAAAAAAAAAA, `rA_address` 7 → `fwdA_data` 0xAA11AA11AA11AA11. With ppp 010 → 0x11111111AAAAAAAA. With `rB_address` 8 → `fwdB_data` unchanged.
- `flush` during WAIT_LOAD, coinciding with `dmem_valid` → no write, state EMPTY, `in_ready` 1 the next cycle.
- 65 536 writes → `wb_count` wraps to 0.
